// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner: double-buffered BCD capture, per-digit decode,
// leading-zero blanking, one dead cycle per slot and a frame-done strobe.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PcntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

  logic [PcntW-1:0]        pcnt_q, pcnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    slot_end, frame_wrap;
  logic [NUM_DIGITS-1:0]   digit_nz;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_code;
  logic                    cur_dp, cur_lz;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      default: g = 7'b1111110;
    endcase
    return g;
  endfunction

  assign slot_end   = enable && (pcnt_q == PcntMax);
  assign frame_wrap = slot_end && (idx_q == IdxMax);

  // Scan counters and buffers; a load on the wrap edge bypasses the shadow.
  always_comb begin
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    if (enable) begin
      pcnt_d = slot_end ? '0 : pcnt_q + PcntW'(1);
    end
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
    end
    if (frame_wrap) begin
      disp_bcd_d = load ? bcd_in : shadow_bcd_q;
      disp_dp_d  = load ? dp_in  : shadow_dp_q;
    end
  end

  always_comb begin
    digit_nz = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      digit_nz[k] = |disp_bcd_q[4*k +: 4];
    end
  end

  // Select the digit under scan; a digit is a leading zero when it and all above it are 0.
  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    an_sel   = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_code  = disp_bcd_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_lz    = (k != 0) && !(|(digit_nz >> k));
        an_sel[k] = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    an_d  = '1;
    fd_d  = frame_wrap;
    if (enable) begin
      seg_d = (lz_en && cur_lz) ? 7'b1111111 : decode(cur_code);
      dp_d  = ~cur_dp;
      if (pcnt_q != '0) begin
        an_d = an_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fd_q         <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a time-based model checked every cycle plus directed literal checks.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg), .dp_out(dp_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  // Model: t counts enabled cycles since reset; slot/digit/frame positions follow arithmetically.
  int          t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [3:0]  exp_an;
  bit          m_valid = 0;

  initial begin
    int pc, ix, dg;
    bit blank, wrap;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0; m_shadow = '0; m_sdp = '0; m_disp = '0; m_ddp = '0;
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
      end else begin
        if (enable) begin
          pc = t % SD;
          ix = (t / SD) % ND;
          dg = int'((m_disp >> (4 * ix)) & 16'hF);
          blank = lz_en && (ix > 0) && ((m_disp >> (4 * ix)) == 16'h0);
          exp_seg = blank ? 7'h7F : glyph(dg);
          exp_dp = ~m_ddp[ix];
          exp_an = (pc == 0) ? 4'hF : ~(4'b0001 << ix);
          wrap = (t % (SD * ND)) == (SD * ND - 1);
          exp_fd = wrap;
          if (wrap) begin
            m_disp = load ? bcd_in : m_shadow;
            m_ddp  = load ? dp_in : m_sdp;
          end
          t++;
        end else begin
          exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
        end
        if (load) begin
          m_shadow = bcd_in;
          m_sdp = dp_in;
        end
      end
      m_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_seg", 32'(seg), 32'(exp_seg));
        chk("model_dp", 32'(dp_out), 32'(exp_dp));
        chk("model_an", 32'(an), 32'(exp_an));
        chk("model_fd", 32'(frame_done), 32'(exp_fd));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd();
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
    chk("frame_done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] a, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an === a) ok = 1;
    end
  endtask

  task automatic check_digit(input string name, input logic [3:0] a, input logic [6:0] s,
                             input logic d);
    bit ok;
    wait_an(a, ok);
    chk({name, "_found"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({name, "_seg"}, 32'(seg), 32'(s));
      chk({name, "_dp"}, 32'(dp_out), 32'(d));
    end
  endtask

  initial begin
    bit ok;
    // 1: reset mid-scan
    enable = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    rst_n = 1'b0;
    tick(3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(negedge clk);
      if (an === 4'b1110) ok = 1;
    end
    chk("rst_first_an", 32'(ok), 32'd1);

    // 2: decode
    lz_en = 1'b0;
    do_load(16'h9876, 4'b0000);
    wait_fd();
    check_digit("d9876_0", 4'b1110, 7'b0100000, 1'b1);
    check_digit("d9876_1", 4'b1101, 7'b0001111, 1'b1);
    check_digit("d9876_2", 4'b1011, 7'b0000000, 1'b1);
    check_digit("d9876_3", 4'b0111, 7'b0000100, 1'b1);
    do_load(16'h5432, 4'b0000);
    wait_fd();
    check_digit("d5432_0", 4'b1110, 7'b0010010, 1'b1);
    check_digit("d5432_1", 4'b1101, 7'b0000110, 1'b1);
    check_digit("d5432_2", 4'b1011, 7'b1001100, 1'b1);
    check_digit("d5432_3", 4'b0111, 7'b0100100, 1'b1);
    do_load(16'h0010, 4'b0000);
    wait_fd();
    check_digit("d0010_0", 4'b1110, 7'b0000001, 1'b1);
    check_digit("d0010_1", 4'b1101, 7'b1001111, 1'b1);
    check_digit("d0010_3", 4'b0111, 7'b0000001, 1'b1);

    // 3: invalid code and decimal point
    do_load(16'h0B00, 4'b0100);
    wait_fd();
    check_digit("inv_0", 4'b1110, 7'b0000001, 1'b1);
    check_digit("inv_2", 4'b1011, 7'b1111110, 1'b0);
    check_digit("inv_3", 4'b0111, 7'b0000001, 1'b1);

    // 4: leading-zero blanking
    lz_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_fd();
    check_digit("lz50_0", 4'b1110, 7'b0000001, 1'b1);
    check_digit("lz50_1", 4'b1101, 7'b0100100, 1'b1);
    check_digit("lz50_2", 4'b1011, 7'b1111111, 1'b1);
    check_digit("lz50_3", 4'b0111, 7'b1111111, 1'b1);
    do_load(16'h0000, 4'b0000);
    wait_fd();
    check_digit("lz00_0", 4'b1110, 7'b0000001, 1'b1);
    check_digit("lz00_1", 4'b1101, 7'b1111111, 1'b1);

    // 5: tear-free double buffering
    lz_en = 1'b0;
    wait_fd();
    tick(3);
    do_load(16'h1111, 4'b0000);
    tick(2);
    do_load(16'h2222, 4'b0000);
    check_digit("tear_old_3", 4'b0111, 7'b0000001, 1'b1);
    wait_fd();
    check_digit("tear_new_0", 4'b1110, 7'b0010010, 1'b1);
    wait_an(4'b0111, ok);
    chk("wrap_sync", 32'(ok), 32'd1);
    @(negedge clk);
    bcd_in = 16'h3333; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_load_fd", 32'(frame_done), 32'd1);
    check_digit("wrap_load_0", 4'b1110, 7'b0000110, 1'b1);

    // 6: enable freeze and resume
    wait_an(4'b1101, ok);
    chk("en_sync", 32'(ok), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_an", 32'(an), 32'hF);
      chk("dis_seg", 32'(seg), 32'h7F);
      chk("dis_fd", 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("resume_an", 32'(an), 32'b1101);
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
